aes_encryp_stream_ctrl: RTL

- Flow-control controller for the fully pipelined AES-128 encryption core (10 key-expansion stages and 10 round stages, no internal valid or stall).
- Wraps the free-running core in a valid/ready stream interface: it registers accepted key/plaintext pairs into the core and tracks each block through the core latency with a valid shift register.
- Captures ciphertext into an output FIFO and uses credit-based admission so that no block is ever lost under downstream backpressure.
- Sits between the upstream block source and the cipher output consumer.

---
 rtl/aes_encryp_stream_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/aes_encryp_stream_ctrl.sv
// Valid/ready stream wrapper around a free-running pipelined AES-128 core.
// Credit-based admission keeps the output FIFO from ever overflowing.
module aes_encryp_stream_ctrl #(
   parameter int CORE_LAT   = 10,
   parameter int FIFO_DEPTH = 16,
   parameter int CNT_W      = 32
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            s_valid,
   output logic                            s_ready,
   input  logic [127:0]                    s_key,
   input  logic [127:0]                    s_plaintext,
   output logic [127:0]                    core_key,
   output logic [127:0]                    core_plaintext,
   input  logic [127:0]                    core_ciphertext,
   output logic                            m_valid,
   input  logic                            m_ready,
   output logic [127:0]                    m_ciphertext,
   output logic [$clog2(FIFO_DEPTH+1)-1:0] in_flight,
   output logic [CNT_W-1:0]                blk_in_cnt,
   output logic [CNT_W-1:0]                blk_out_cnt
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int IW = $clog2(FIFO_DEPTH+1);
   localparam logic [IW:0] DEPTH_V = (IW+1)'(FIFO_DEPTH);

   logic [CORE_LAT:0] vld_sr;
   logic [127:0]      mem [FIFO_DEPTH];
   logic [AW-1:0]     wr_ptr;
   logic [AW-1:0]     rd_ptr;
   logic [IW-1:0]     fifo_count;
   logic [IW:0]       occupancy;
   logic              accept;
   logic              wr_en;
   logic              pop;

   assign accept       = s_valid && s_ready;
   assign wr_en        = vld_sr[CORE_LAT];
   assign pop          = m_valid && m_ready;
   // Credits come from registers only, so s_ready never sees s_valid/m_ready.
   assign occupancy    = {1'b0, in_flight} + {1'b0, fifo_count};
   assign s_ready      = occupancy < DEPTH_V;
   assign m_valid      = fifo_count != '0;
   assign m_ciphertext = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vld_sr         <= '0;
         core_key       <= '0;
         core_plaintext <= '0;
      end else begin
         vld_sr <= {vld_sr[CORE_LAT-1:0], accept};
         if (accept) begin
            core_key       <= s_key;
            core_plaintext <= s_plaintext;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= core_ciphertext;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
      end else begin
         if (wr_en) wr_ptr <= wr_ptr + AW'(1);
         if (pop)   rd_ptr <= rd_ptr + AW'(1);
         unique case ({wr_en, pop})
            2'b10:   fifo_count <= fifo_count + IW'(1);
            2'b01:   fifo_count <= fifo_count - IW'(1);
            default: fifo_count <= fifo_count;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         in_flight <= '0;
      end else begin
         unique case ({accept, wr_en})
            2'b10:   in_flight <= in_flight + IW'(1);
            2'b01:   in_flight <= in_flight - IW'(1);
            default: in_flight <= in_flight;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         blk_in_cnt  <= '0;
         blk_out_cnt <= '0;
      end else begin
         if (accept) blk_in_cnt  <= blk_in_cnt + CNT_W'(1);
         if (pop)    blk_out_cnt <= blk_out_cnt + CNT_W'(1);
      end
   end

endmodule
